// File: rtl/crc_pkg.sv
// Shared types for the CRC request front end: request and parameter records,
// polynomial select codes and the record-build helper.
package crc_pkg;

    localparam logic [1:0] POLY_SEL_32 = 2'b00;
    localparam logic [1:0] POLY_SEL_16 = 2'b01;
    localparam logic [1:0] POLY_SEL_64 = 2'b11;

    typedef struct packed {
        logic [1:0]  crc_poly_size_sel;
        logic [7:0]  req_id;
        logic [31:0] data_addr_offset;
        logic [31:0] crc_addr_offset;
        logic        req_rpt_en;
    } crc_req_t;

    typedef struct packed {
        logic [1:0]  crc_poly_size_sel;
        logic [7:0]  req_id;
        logic [63:0] poly;
        logic [31:0] data_addr;
        logic [31:0] crc_addr;
        logic [2:0]  rpt_num;
    } crc_param_req_t;

    localparam int CRC_REQ_WITDH       = $bits(crc_req_t);
    localparam int CRC_PARAM_REQ_WITDH = $bits(crc_param_req_t);

    // sel=2'b10 has bit 0 clear, so it falls into the 32-bit default.
    function automatic crc_param_req_t build_param(
        input crc_req_t    req,
        input logic [15:0] poly16,
        input logic [31:0] poly32,
        input logic [63:0] poly64,
        input logic [31:0] data_ba,
        input logic [31:0] crc_ba,
        input logic [2:0]  rpt_num
    );
        crc_param_req_t rec;
        rec.crc_poly_size_sel = req.crc_poly_size_sel;
        rec.req_id            = req.req_id;
        case (req.crc_poly_size_sel)
            POLY_SEL_16: rec.poly = {48'h0, poly16};
            POLY_SEL_64: rec.poly = poly64;
            default:     rec.poly = {32'h0, poly32};
        endcase
        rec.data_addr = data_ba + req.data_addr_offset;
        rec.crc_addr  = crc_ba + req.crc_addr_offset;
        rec.rpt_num   = req.req_rpt_en ? rpt_num : 3'd0;
        return rec;
    endfunction

endpackage

// File: rtl/basic_fifo.sv
// Small synchronous FIFO; a write into a full FIFO is taken only when a read
// happens in the same cycle.
module basic_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             i_clk,
    input  logic             i_nreset,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_pop     = i_rd_en & ~o_empty;
    assign w_push    = i_wr_en & (~o_full | w_pop);
    assign o_rd_data = r_mem[r_rd_ptr];

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge i_clk or negedge i_nreset) begin
        if (!i_nreset) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_wr_data;
                r_wr_ptr        <= next_ptr(r_wr_ptr);
            end
            if (w_pop) r_rd_ptr <= next_ptr(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/crc_rr_arb.sv
// Round-robin arbiter: search starts one past the last granted channel and
// wraps; reset state makes channel 0 the first winner.
module crc_rr_arb #(
    parameter  int NUM_CH = 4,
    localparam int CHW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              i_clk,
    input  logic              i_nreset,
    input  logic [NUM_CH-1:0] i_req,
    input  logic              i_en,
    output logic [NUM_CH-1:0] o_gnt,
    output logic [CHW-1:0]    o_gnt_idx,
    output logic [CHW-1:0]    o_last_grant
);
    logic [CHW-1:0] r_last;
    logic [CHW-1:0] w_idx;
    logic [CHW-1:0] w_cand;
    logic           w_found;

    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        w_cand  = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            w_cand = CHW'((int'(r_last) + k) % NUM_CH);
            if (!w_found && i_req[w_cand]) begin
                w_found = 1'b1;
                w_idx   = w_cand;
            end
        end
    end

    assign o_gnt        = (i_en && w_found) ? (NUM_CH'(1) << w_idx) : '0;
    assign o_gnt_idx    = w_idx;
    assign o_last_grant = r_last;

    always_ff @(posedge i_clk or negedge i_nreset) begin
        if (!i_nreset)   r_last <= CHW'(NUM_CH - 1);
        else if (|o_gnt) r_last <= w_idx;
    end

endmodule

// File: rtl/crc_req_proc_mc.sv
// Multi-channel CRC request front end: per-channel request FIFOs, round-robin
// expansion into CRC parameter records, and per-channel outstanding tracking.
module crc_req_proc_mc
    import crc_pkg::*;
#(
    parameter  int NUM_CH           = 4,
    parameter  int REQ_FIFO_DEPTH   = 2,
    parameter  int PARAM_FIFO_DEPTH = 2,
    parameter  int MAX_OUTSTAND     = 8,
    localparam int CHW              = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int OCW              = $clog2(MAX_OUTSTAND + 1)
) (
    input  logic                                    i_clk,
    input  logic                                    i_nreset,
    input  logic [NUM_CH-1:0]                       i_req_valid,
    input  logic [NUM_CH-1:0][CRC_REQ_WITDH-1:0]    i_req_data,
    output logic [NUM_CH-1:0]                       o_req_ready,
    output logic                                    o_crc_params_valid,
    output logic [CRC_PARAM_REQ_WITDH-1:0]          o_crc_params_data,
    output logic [CHW-1:0]                          o_crc_params_ch,
    input  logic                                    i_crc_params_ready,
    input  logic [15:0]                             i_cfg_16bit_poly,
    input  logic [31:0]                             i_cfg_32bit_poly,
    input  logic [63:0]                             i_cfg_64bit_poly,
    input  logic [31:0]                             i_cfg_data_ba,
    input  logic [31:0]                             i_cfg_crc_ba,
    input  logic [2:0]                              i_cfg_rpt_num,
    input  logic                                    i_outstand_dec,
    input  logic [CHW-1:0]                          i_outstand_dec_ch,
    output logic [NUM_CH-1:0]                       o_no_outstand_cmd,
    output logic                                    o_outstand_err
);
    logic [NUM_CH-1:0]                    w_rf_full;
    logic [NUM_CH-1:0]                    w_rf_empty;
    logic [NUM_CH-1:0][CRC_REQ_WITDH-1:0] w_rf_data;
    logic [NUM_CH-1:0]                    w_accept;
    logic [NUM_CH-1:0]                    w_dec;
    logic [NUM_CH-1:0]                    w_dec_ok;
    logic [NUM_CH-1:0]                    w_dec_zero;
    logic [NUM_CH-1:0]                    w_gnt;
    logic [CHW-1:0]                       w_gnt_idx;
    logic [CHW-1:0]                       w_last_grant_unused;
    logic                                 w_pf_full;
    logic                                 w_pf_empty;
    logic                                 w_pf_pop;
    logic                                 w_arb_en;
    logic                                 w_dec_bad;
    logic [CRC_PARAM_REQ_WITDH+CHW-1:0]   w_pf_rd_data;
    crc_req_t                             w_head;
    crc_param_req_t                       w_rec;
    logic [OCW-1:0]                       r_cnt [NUM_CH];
    logic                                 r_err;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign o_req_ready[c]       = ~w_rf_full[c] & (r_cnt[c] != OCW'(MAX_OUTSTAND));
        assign w_accept[c]          = i_req_valid[c] & o_req_ready[c];
        assign o_no_outstand_cmd[c] = (r_cnt[c] == '0);
        assign w_dec[c]             = i_outstand_dec & (i_outstand_dec_ch == CHW'(c));
        assign w_dec_ok[c]          = w_dec[c] & (r_cnt[c] != '0);
        assign w_dec_zero[c]        = w_dec[c] & (r_cnt[c] == '0);

        basic_fifo #(
            .WIDTH (CRC_REQ_WITDH),
            .DEPTH (REQ_FIFO_DEPTH)
        ) u_req_fifo (
            .i_clk     (i_clk),
            .i_nreset  (i_nreset),
            .i_wr_en   (w_accept[c]),
            .i_wr_data (i_req_data[c]),
            .i_rd_en   (w_gnt[c]),
            .o_rd_data (w_rf_data[c]),
            .o_full    (w_rf_full[c]),
            .o_empty   (w_rf_empty[c])
        );

        // Accept and a valid decrement in the same cycle cancel out.
        always_ff @(posedge i_clk or negedge i_nreset) begin
            if (!i_nreset)                      r_cnt[c] <= '0;
            else if (w_accept[c] && !w_dec_ok[c]) r_cnt[c] <= r_cnt[c] + 1'b1;
            else if (!w_accept[c] && w_dec_ok[c]) r_cnt[c] <= r_cnt[c] - 1'b1;
        end
    end

    // A full parameter FIFO that is draining this cycle can still take a record.
    assign w_pf_pop = o_crc_params_valid & i_crc_params_ready;
    assign w_arb_en = ~w_pf_full | w_pf_pop;

    crc_rr_arb #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .i_clk        (i_clk),
        .i_nreset     (i_nreset),
        .i_req        (~w_rf_empty),
        .i_en         (w_arb_en),
        .o_gnt        (w_gnt),
        .o_gnt_idx    (w_gnt_idx),
        .o_last_grant (w_last_grant_unused)
    );

    assign w_head = crc_req_t'(w_rf_data[w_gnt_idx]);
    assign w_rec  = build_param(w_head, i_cfg_16bit_poly, i_cfg_32bit_poly, i_cfg_64bit_poly,
                                i_cfg_data_ba, i_cfg_crc_ba, i_cfg_rpt_num);

    basic_fifo #(
        .WIDTH (CRC_PARAM_REQ_WITDH + CHW),
        .DEPTH (PARAM_FIFO_DEPTH)
    ) u_param_fifo (
        .i_clk     (i_clk),
        .i_nreset  (i_nreset),
        .i_wr_en   (|w_gnt),
        .i_wr_data ({w_rec, w_gnt_idx}),
        .i_rd_en   (w_pf_pop),
        .o_rd_data (w_pf_rd_data),
        .o_full    (w_pf_full),
        .o_empty   (w_pf_empty)
    );

    assign o_crc_params_valid = ~w_pf_empty;
    assign o_crc_params_data  = w_pf_rd_data[CRC_PARAM_REQ_WITDH+CHW-1:CHW];
    assign o_crc_params_ch    = w_pf_rd_data[CHW-1:0];

    assign w_dec_bad = i_outstand_dec & ({1'b0, i_outstand_dec_ch} >= (CHW + 1)'(NUM_CH));

    always_ff @(posedge i_clk or negedge i_nreset) begin
        if (!i_nreset)                        r_err <= 1'b0;
        else if (w_dec_bad || (|w_dec_zero))  r_err <= 1'b1;
    end

    assign o_outstand_err = r_err;

endmodule

// File: tb/tb_crc_req_proc_mc.sv
// Bench for crc_req_proc_mc: directed steps plus random traffic scored against
// per-channel request queues and an arithmetic record model.
module tb_crc_req_proc_mc;
    import crc_pkg::*;

    localparam int NUM_CH = 4;
    localparam int MAXO   = 8;
    localparam int CHW    = 2;

    logic                                 clk = 1'b0;
    logic                                 nreset = 1'b0;
    logic [NUM_CH-1:0]                    req_valid;
    logic [NUM_CH-1:0][CRC_REQ_WITDH-1:0] req_data;
    logic [NUM_CH-1:0]                    req_ready;
    logic                                 p_valid;
    logic [CRC_PARAM_REQ_WITDH-1:0]       p_data;
    logic [CHW-1:0]                       p_ch;
    logic                                 p_ready;
    logic [15:0]                          cfg_p16;
    logic [31:0]                          cfg_p32;
    logic [63:0]                          cfg_p64;
    logic [31:0]                          cfg_dba;
    logic [31:0]                          cfg_cba;
    logic [2:0]                           cfg_rpt;
    logic                                 dec;
    logic [CHW-1:0]                       dec_ch;
    logic [NUM_CH-1:0]                    no_outst;
    logic                                 outst_err;

    int             checks = 0;
    int             errors = 0;
    crc_req_t       exp_q [NUM_CH][$];
    int             m_cnt [NUM_CH];
    bit             m_err;
    int             pop_log [$];
    crc_param_req_t pr;

    always #5 clk = ~clk;

    crc_req_proc_mc dut (
        .i_clk              (clk),
        .i_nreset           (nreset),
        .i_req_valid        (req_valid),
        .i_req_data         (req_data),
        .o_req_ready        (req_ready),
        .o_crc_params_valid (p_valid),
        .o_crc_params_data  (p_data),
        .o_crc_params_ch    (p_ch),
        .i_crc_params_ready (p_ready),
        .i_cfg_16bit_poly   (cfg_p16),
        .i_cfg_32bit_poly   (cfg_p32),
        .i_cfg_64bit_poly   (cfg_p64),
        .i_cfg_data_ba      (cfg_dba),
        .i_cfg_crc_ba       (cfg_cba),
        .i_cfg_rpt_num      (cfg_rpt),
        .i_outstand_dec     (dec),
        .i_outstand_dec_ch  (dec_ch),
        .o_no_outstand_cmd  (no_outst),
        .o_outstand_err     (outst_err)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic crc_req_t mk_req(input logic [1:0] sel, input logic [7:0] id,
                                        input logic [31:0] doff, input logic [31:0] coff,
                                        input logic rpt_en);
        crc_req_t r;
        r.crc_poly_size_sel = sel;
        r.req_id            = id;
        r.data_addr_offset  = doff;
        r.crc_addr_offset   = coff;
        r.req_rpt_en        = rpt_en;
        return r;
    endfunction

    function automatic crc_req_t rand_req();
        return mk_req(2'($urandom_range(0, 3)), 8'($urandom), $urandom, $urandom,
                      1'($urandom_range(0, 1)));
    endfunction

    // Expected record from plain arithmetic on the request and current config.
    function automatic crc_param_req_t model_rec(input crc_req_t rq);
        crc_param_req_t   r;
        longint unsigned  a;
        r.crc_poly_size_sel = rq.crc_poly_size_sel;
        r.req_id            = rq.req_id;
        if (rq.crc_poly_size_sel == 2'b11)      r.poly = cfg_p64;
        else if (rq.crc_poly_size_sel == 2'b01) r.poly = 64'(cfg_p16);
        else                                    r.poly = 64'(cfg_p32);
        a = (64'(cfg_dba) + 64'(rq.data_addr_offset)) % 64'h1_0000_0000;
        r.data_addr = a[31:0];
        a = (64'(cfg_cba) + 64'(rq.crc_addr_offset)) % 64'h1_0000_0000;
        r.crc_addr = a[31:0];
        r.rpt_num  = rq.req_rpt_en ? cfg_rpt : 3'd0;
        return r;
    endfunction

    function automatic int pending();
        int n = 0;
        for (int c = 0; c < NUM_CH; c++) n += exp_q[c].size();
        return n;
    endfunction

    function automatic logic [NUM_CH-1:0] exp_idle();
        logic [NUM_CH-1:0] v;
        for (int c = 0; c < NUM_CH; c++) v[c] = (m_cnt[c] == 0);
        return v;
    endfunction

    // Observe this cycle's handshakes, advance one clock, check tracked state.
    task automatic tick();
        int dch;
        int inc [NUM_CH];
        if (p_valid && p_ready) begin
            int ch = int'(p_ch);
            pop_log.push_back(ch);
            chk("sb_has_entry", exp_q[ch].size() > 0, 1'b1);
            if (exp_q[ch].size() > 0) chk("rec", p_data, model_rec(exp_q[ch].pop_front()));
        end
        for (int c = 0; c < NUM_CH; c++) begin
            inc[c] = 0;
            if (req_valid[c] && req_ready[c]) begin
                exp_q[c].push_back(crc_req_t'(req_data[c]));
                inc[c] = 1;
            end
        end
        if (dec) begin
            dch = int'(dec_ch);
            if (dch >= NUM_CH || m_cnt[dch] == 0) m_err = 1'b1;
            else m_cnt[dch]--;
        end
        for (int c = 0; c < NUM_CH; c++) m_cnt[c] += inc[c];
        @(posedge clk); #1;
        chk("no_outstand", no_outst, exp_idle());
        chk("outstand_err", outst_err, m_err);
        for (int c = 0; c < NUM_CH; c++)
            if (m_cnt[c] == MAXO) chk("ready_at_max", req_ready[c], 1'b0);
    endtask

    task automatic drain();
        req_valid = '0;
        dec       = 1'b0;
        p_ready   = 1'b1;
        for (int i = 0; i < 60 && (pending() > 0 || p_valid); i++) tick();
        chk("drain_done", pending(), 0);
    endtask

    task automatic zero_cnt();
        for (int c = 0; c < NUM_CH; c++) begin
            while (m_cnt[c] > 0) begin
                dec    = 1'b1;
                dec_ch = CHW'(c);
                tick();
            end
        end
        dec = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_ready"}, req_ready, 4'hF);
        chk({tag, "_pvalid"}, p_valid, 1'b0);
        chk({tag, "_pdata"}, p_data, '0);
        chk({tag, "_pch"}, p_ch, 2'd0);
        chk({tag, "_idle"}, no_outst, 4'hF);
        chk({tag, "_err"}, outst_err, 1'b0);
    endtask

    initial begin
        req_valid = '0;
        req_data  = '0;
        p_ready   = 1'b0;
        dec       = 1'b0;
        dec_ch    = '0;
        cfg_p16   = 16'h8005;
        cfg_p32   = 32'h04C1_1DB7;
        cfg_p64   = 64'h42F0_E1EB_A9EA_3693;
        cfg_dba   = 32'h0000_1000;
        cfg_cba   = 32'h0000_2000;
        cfg_rpt   = 3'd5;
        m_err     = 1'b0;
        for (int c = 0; c < NUM_CH; c++) m_cnt[c] = 0;

        repeat (3) @(posedge clk);
        #1;
        check_reset("rst");
        nreset = 1'b1;
        @(posedge clk); #1;

        // Single request on ch0: record visible two cycles after accept.
        p_ready     = 1'b1;
        req_data[0] = mk_req(2'b11, 8'h11, 32'h10, 32'h4, 1'b1);
        req_valid   = 4'b0001;
        tick();
        req_valid = '0;
        chk("lat_c1_valid", p_valid, 1'b0);
        tick();
        pr = p_data;
        chk("lat_c2_valid", p_valid, 1'b1);
        chk("t1_ch", p_ch, 2'd0);
        chk("t1_poly", pr.poly, 64'h42F0_E1EB_A9EA_3693);
        chk("t1_daddr", pr.data_addr, 32'h0000_1010);
        chk("t1_caddr", pr.crc_addr, 32'h0000_2004);
        chk("t1_rpt", pr.rpt_num, 3'd5);
        tick();

        // Address wrap, 32-bit poly, repeat disabled on ch1; 16-bit poly on ch2.
        cfg_dba     = 32'hFFFF_FFF0;
        req_data[1] = mk_req(2'b00, 8'h22, 32'h20, 32'h0, 1'b0);
        req_valid   = 4'b0010;
        tick();
        req_valid = '0;
        tick();
        pr = p_data;
        chk("wrap_valid", p_valid, 1'b1);
        chk("wrap_ch", p_ch, 2'd1);
        chk("wrap_daddr", pr.data_addr, 32'h0000_0010);
        chk("sel00_poly", pr.poly, 64'h0000_0000_04C1_1DB7);
        chk("rpt_off", pr.rpt_num, 3'd0);
        req_data[2] = mk_req(2'b01, 8'h33, 32'h0, 32'h0, 1'b1);
        req_valid   = 4'b0100;
        tick();
        req_valid = '0;
        tick();
        pr = p_data;
        chk("sel01_poly", pr.poly, 64'h0000_0000_0000_8005);
        drain();
        cfg_dba = 32'h0000_1000;

        // All channels loaded: strict rotation, one record every cycle.
        pop_log.delete();
        for (int k = 0; k < 24; k++) begin
            for (int c = 0; c < NUM_CH; c++) req_data[c] = rand_req();
            req_valid = '1;
            dec_ch    = CHW'(k % NUM_CH);
            dec       = (m_cnt[k % NUM_CH] > 0);
            tick();
            if (k >= 1) chk("rr_stream_valid", p_valid, 1'b1);
        end
        req_valid = '0;
        dec       = 1'b0;
        for (int i = 1; i < pop_log.size(); i++)
            chk("rr_order", pop_log[i], (pop_log[i-1] + 1) % NUM_CH);
        drain();
        zero_cnt();

        // Outstanding limit on ch2.
        for (int i = 0; i < 40 && m_cnt[2] < MAXO; i++) begin
            req_data[2] = rand_req();
            req_valid   = 4'b0100;
            tick();
        end
        req_valid = '0;
        chk("lim_cnt", m_cnt[2], MAXO);
        chk("lim_ready_low", req_ready[2], 1'b0);
        chk("lim_busy", no_outst[2], 1'b0);
        tick();
        tick();
        chk("lim_ready_still_low", req_ready[2], 1'b0);
        dec    = 1'b1;
        dec_ch = 2'd2;
        tick();
        dec = 1'b0;
        chk("lim_ready_back", req_ready[2], 1'b1);
        zero_cnt();
        chk("lim_idle_again", no_outst[2], 1'b1);
        drain();

        // Backpressure: last grant was ch2, so ch3 heads the stalled queue.
        p_ready = 1'b0;
        for (int k = 0; k < 12; k++) begin
            for (int c = 0; c < NUM_CH; c++) req_data[c] = rand_req();
            req_valid = '1;
            tick();
            if (k >= 1) begin
                chk("bp_head_valid", p_valid, 1'b1);
                chk("bp_head_ch", p_ch, 2'd3);
                if (exp_q[3].size() > 0) chk("bp_head_rec", p_data, model_rec(exp_q[3][0]));
            end
        end
        chk("bp_all_blocked", req_ready, 4'h0);

        // Random traffic, random backpressure and decrements.
        for (int k = 0; k < 300; k++) begin
            for (int c = 0; c < NUM_CH; c++) req_data[c] = rand_req();
            req_valid = 4'($urandom);
            p_ready   = 1'($urandom);
            dec_ch    = CHW'($urandom_range(0, NUM_CH - 1));
            dec       = ($urandom_range(0, 3) == 0) && (m_cnt[dec_ch] > 0);
            tick();
        end
        drain();
        zero_cnt();

        // Decrement at zero sets a sticky error.
        chk("err_clear", outst_err, 1'b0);
        dec    = 1'b1;
        dec_ch = 2'd0;
        tick();
        dec = 1'b0;
        chk("err_set", outst_err, 1'b1);
        repeat (3) tick();
        chk("err_sticky", outst_err, 1'b1);

        // Simultaneous accept and decrement leaves the count unchanged.
        req_data[1] = rand_req();
        req_valid   = 4'b0010;
        tick();
        req_data[1] = rand_req();
        dec         = 1'b1;
        dec_ch      = 2'd1;
        tick();
        req_valid = '0;
        dec       = 1'b0;
        chk("incdec_busy", no_outst[1], 1'b0);
        dec = 1'b1;
        tick();
        dec = 1'b0;
        chk("incdec_one_left", no_outst[1], 1'b1);
        drain();

        // Reset in the middle of a stalled burst.
        p_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            for (int c = 0; c < NUM_CH; c++) req_data[c] = rand_req();
            req_valid = '1;
            tick();
        end
        chk("pre_rst_loaded", p_valid, 1'b1);
        nreset = 1'b0;
        #2;
        check_reset("midrst");
        for (int c = 0; c < NUM_CH; c++) begin
            exp_q[c].delete();
            m_cnt[c] = 0;
        end
        m_err     = 1'b0;
        req_valid = '0;
        @(posedge clk); #1;
        nreset = 1'b1;
        @(posedge clk); #1;
        check_reset("postrst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
